// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost collision path.
package ghost_pkg;

    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } coll_state_t;

    // Bit positions inside obst_dr / collision_src
    localparam int SRC_WALL    = 0;
    localparam int SRC_PLAYER  = 1;
    localparam int SRC_MISSILE = 2;

    localparam int DEFAULT_COORD_W = 11;

endpackage

// File: rtl/frame_hold_counter.sv
// Loadable 8-bit down-counter stepped once per frame boundary.
// done_o flags the step that takes the count from 1 to 0.
module frame_hold_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       step_i,
    output logic       done_o
);

    logic [7:0] count_q, count_d;

    // Load has priority; stepping stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (step_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    assign done_o = step_i && !load_i && (count_q == 8'd1);

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ghost_collision_detector.sv
// Accumulates ghost/obstacle overlaps over a frame and issues at most one
// collision pulse per frame boundary, followed by a frame-based cooldown.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARMED    | accumulating overlaps; a non-empty frame fires at the boundary
// COOLDOWN | overlaps ignored; counts frame boundaries until re-armed
module ghost_collision_detector
    import ghost_pkg::*;
#(
    parameter int NUM_SRC         = 3,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int COORD_W         = DEFAULT_COORD_W
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               ghost_dr,
    input  logic [NUM_SRC-1:0] obst_dr,
    input  logic               enable,
    output logic               collision,
    output logic [NUM_SRC-1:0] collision_src,
    output logic [COORD_W-1:0] hit_x,
    output logic [COORD_W-1:0] hit_y,
    output logic [15:0]        hit_count,
    output logic               cooling
);

    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);
    localparam bit         HAS_CD  = (COOLDOWN_FRAMES != 0);

    coll_state_t        state_q, state_d;
    logic [NUM_SRC-1:0] acc_mask_q;
    logic               first_seen_q;
    logic [COORD_W-1:0] hit_x_acc_q, hit_y_acc_q;
    logic               collision_q;
    logic [NUM_SRC-1:0] collision_src_q;
    logic [COORD_W-1:0] hit_x_q, hit_y_q;
    logic [15:0]        hit_count_q;

    logic ov;
    logic accumulate;
    logic fire;
    logic cd_load;
    logic cd_step;
    logic cd_done;

    assign ov         = ghost_dr & (|obst_dr);
    assign accumulate = (state_q == ARMED) && enable && !startOfFrame;
    // enable gates the pulse too, so a frame closed while disabled never fires
    assign fire       = startOfFrame && (state_q == ARMED) && enable && (acc_mask_q != '0);
    assign cd_load    = fire && HAS_CD;
    assign cd_step    = startOfFrame && (state_q == COOLDOWN);

    frame_hold_counter u_cooldown (
        .clk        (clk),
        .rst_n      (resetN),
        .load_i     (cd_load),
        .load_val_i (CD_LOAD),
        .step_i     (cd_step),
        .done_o     (cd_done)
    );

    // Next-state: arm -> cooldown on a pulse, back to armed when the count expires
    always_comb begin
        state_d = state_q;
        if (cd_load) begin
            state_d = COOLDOWN;
        end else if (cd_done) begin
            state_d = ARMED;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-frame accumulator; cleared at every boundary, while disabled or cooling
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_mask_q   <= '0;
            first_seen_q <= 1'b0;
            hit_x_acc_q  <= '0;
            hit_y_acc_q  <= '0;
        end else if (!accumulate) begin
            acc_mask_q   <= '0;
            first_seen_q <= 1'b0;
        end else begin
            acc_mask_q <= acc_mask_q | (obst_dr & {NUM_SRC{ghost_dr}});
            if (ov && !first_seen_q) begin
                hit_x_acc_q  <= pixelX;
                hit_y_acc_q  <= pixelY;
                first_seen_q <= 1'b1;
            end
        end
    end

    // Report registers: one-cycle pulse, held frame summary, saturating pulse count
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision_q     <= 1'b0;
            collision_src_q <= '0;
            hit_x_q         <= '0;
            hit_y_q         <= '0;
            hit_count_q     <= 16'd0;
        end else begin
            collision_q <= fire;
            if (fire) begin
                collision_src_q <= acc_mask_q;
                hit_x_q         <= hit_x_acc_q;
                hit_y_q         <= hit_y_acc_q;
                if (hit_count_q != 16'hFFFF) begin
                    hit_count_q <= hit_count_q + 16'd1;
                end
            end
        end
    end

    assign collision     = collision_q;
    assign collision_src = collision_src_q;
    assign hit_x         = hit_x_q;
    assign hit_y         = hit_y_q;
    assign hit_count     = hit_count_q;
    assign cooling       = (state_q == COOLDOWN);

endmodule
